// File: rtl/dffram_port_arbiter.sv
// rtl/dffram_port_arbiter.sv - shares the single-port DFFRAM between the Wishbone port and the read-only housekeeping port
module dffram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  input  logic                  ro_req_i,
  input  logic [ADDR_W-1:0]     ro_addr_i,
  output logic                  ro_ack_o,
  output logic [DATA_W-1:0]     ro_data_o,
  output logic                  ram_en_o,
  output logic [DATA_W/8-1:0]   ram_we_o,
  output logic [ADDR_W-1:0]     ram_a_o,
  output logic [DATA_W-1:0]     ram_di_o,
  input  logic [DATA_W-1:0]     ram_do_i,
  output logic [15:0]           stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_RESP = 2'd1,
    RO_RESP = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant_wb;
  logic [DATA_W-1:0]   ro_data_q;
  logic [15:0]         stall_cnt;

  logic                wb_pend;
  logic                ro_pend;
  logic                grant_wb;
  logic                grant_ro;
  logic                stall_evt;
  logic [ADDR_W-1:0]   wb_word;
  logic                unused_adr_bits;

  assign wb_pend = wb_cyc_i & wb_stb_i;
  assign ro_pend = ro_req_i;

  // Byte address to word address; upper bits are dropped so addresses alias.
  assign wb_word         = wb_adr_i[ADDR_W+1:2];
  assign unused_adr_bits = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

  // Grants only happen in IDLE; on a tie FAIR picks whoever did not win last.
  always_comb begin
    grant_wb = 1'b0;
    grant_ro = 1'b0;
    if (!core_rst && state == IDLE) begin
      if (wb_pend && ro_pend) begin
        if (FAIR == 0 || !last_grant_wb) begin
          grant_wb = 1'b1;
        end else begin
          grant_ro = 1'b1;
        end
      end else begin
        grant_wb = wb_pend;
        grant_ro = ro_pend;
      end
    end
  end

  // RAM strobes are driven straight from the grant so the access lands in the grant cycle.
  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = '0;
    ram_a_o  = '0;
    ram_di_o = '0;
    if (grant_wb) begin
      ram_en_o = 1'b1;
      ram_a_o  = wb_word;
      if (wb_we_i) begin
        ram_we_o = wb_sel_i;
        ram_di_o = wb_dat_i;
      end
    end else if (grant_ro) begin
      ram_en_o = 1'b1;
      ram_a_o  = ro_addr_i;
    end
  end

  // A cycle counts as a stall when some requester is waiting and is not the one being served.
  always_comb begin
    stall_evt = 1'b0;
    case (state)
      IDLE:    stall_evt = wb_pend & ro_pend;
      WB_RESP: stall_evt = ro_pend;
      RO_RESP: stall_evt = wb_pend;
      default: stall_evt = wb_pend | ro_pend;
    endcase
  end

  // Arbiter FSM: grant in IDLE, one response cycle, back to IDLE.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state         <= IDLE;
      last_grant_wb <= 1'b0;
      ro_data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wb) begin
            state         <= WB_RESP;
            last_grant_wb <= 1'b1;
          end else if (grant_ro) begin
            state         <= RO_RESP;
            last_grant_wb <= 1'b0;
          end
        end
        WB_RESP: begin
          state <= IDLE;
        end
        RO_RESP: begin
          ro_data_q <= ram_do_i;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      stall_cnt <= '0;
    end else if (stall_evt && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // RAM read data is only valid in the response cycle, so acks and data bypass from ram_do_i there.
  assign wb_ack_o    = !core_rst && state == WB_RESP && wb_cyc_i;
  assign wb_dat_o    = wb_ack_o ? ram_do_i : '0;
  assign ro_ack_o    = !core_rst && state == RO_RESP;
  assign ro_data_o   = core_rst ? '0 : (ro_ack_o ? ram_do_i : ro_data_q);
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// tb/tb_dffram_port_arbiter.sv - directed scoreboard bench for dffram_port_arbiter
module tb_dffram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic        ro_req;
  logic [7:0]  ro_addr;

  logic [31:0] f1_wb_dat, f1_ro_data, f1_ram_di, f1_ram_do;
  logic        f1_wb_ack, f1_ro_ack, f1_ram_en;
  logic [3:0]  f1_ram_we;
  logic [7:0]  f1_ram_a;
  logic [15:0] f1_stall;

  logic [31:0] f0_wb_dat, f0_ro_data, f0_ram_di, f0_ram_do;
  logic        f0_wb_ack, f0_ro_ack, f0_ram_en;
  logic [3:0]  f0_ram_we;
  logic [7:0]  f0_ram_a;
  logic [15:0] f0_stall;

  logic [31:0] mem1 [256];
  logic [31:0] mem0 [256];
  logic [31:0] model [256];
  logic [31:0] wb_q [$];
  logic [31:0] ro_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dffram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .FAIR(1)) dut (
    .core_clk(clk), .core_rst(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(f1_wb_dat), .wb_ack_o(f1_wb_ack),
    .ro_req_i(ro_req), .ro_addr_i(ro_addr), .ro_ack_o(f1_ro_ack), .ro_data_o(f1_ro_data),
    .ram_en_o(f1_ram_en), .ram_we_o(f1_ram_we), .ram_a_o(f1_ram_a), .ram_di_o(f1_ram_di),
    .ram_do_i(f1_ram_do), .stall_cnt_o(f1_stall)
  );

  dffram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .FAIR(0)) dut0 (
    .core_clk(clk), .core_rst(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(f0_wb_dat), .wb_ack_o(f0_wb_ack),
    .ro_req_i(ro_req), .ro_addr_i(ro_addr), .ro_ack_o(f0_ro_ack), .ro_data_o(f0_ro_data),
    .ram_en_o(f0_ram_en), .ram_we_o(f0_ram_we), .ram_a_o(f0_ram_a), .ram_di_o(f0_ram_di),
    .ram_do_i(f0_ram_do), .stall_cnt_o(f0_stall)
  );

  // Behavioural DFFRAM for each instance: byte writes, read data one cycle later.
  always @(posedge clk) begin
    if (f1_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (f1_ram_we[b]) mem1[f1_ram_a][8*b +: 8] <= f1_ram_di[8*b +: 8];
      f1_ram_do <= mem1[f1_ram_a];
    end
  end

  always @(posedge clk) begin
    if (f0_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (f0_ram_we[b]) mem0[f0_ram_a][8*b +: 8] <= f0_ram_di[8*b +: 8];
      f0_ram_do <= mem0[f0_ram_a];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone access on the FAIR=1 instance: grant cycle, ack cycle, then release.
  task automatic wb_access(input string tag, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [7:0] exp_a);
    logic [31:0] exp_d;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat = dat;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) model[exp_a][8*b +: 8] = dat[8*b +: 8];
    end else begin
      wb_q.push_back(model[exp_a]);
    end
    @(negedge clk);
    chk({tag, "_en"}, 32'(f1_ram_en), 32'd1);
    chk({tag, "_a"},  32'(f1_ram_a), 32'(exp_a));
    chk({tag, "_we"}, 32'(f1_ram_we), we ? 32'(sel) : 32'd0);
    if (we) chk({tag, "_di"}, f1_ram_di, dat);
    next_cycle();
    @(negedge clk);
    chk({tag, "_ack"}, 32'(f1_wb_ack), 32'd1);
    if (!we) begin
      exp_d = wb_q.pop_front();
      chk({tag, "_dat"}, f1_wb_dat, exp_d);
    end
    next_cycle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    int a300;
    int n_ro0, n_wb0, n_ro1;
    logic [31:0] exp_d;

    rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat = 0;
    ro_req = 0; ro_addr = 0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_en",     32'(f1_ram_en), 32'd0);
    chk("rst_stall",  32'(f1_stall), 32'd0);
    chk("rst_wbak",   32'(f1_wb_ack), 32'd0);
    chk("rst_roak",   32'(f1_ro_ack), 32'd0);
    chk("rst_rodata", f1_ro_data, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Full-word write then read back
    wb_access("t1_wr", 1'b1, 4'hF, 32'd5 << 2, 32'hDEADBEEF, 8'd5);
    wb_access("t1_rd", 1'b0, 4'hF, 32'd5 << 2, 32'h0, 8'd5);

    // Single byte lane write, zero-select write, read back
    wb_access("t2_wr",  1'b1, 4'b0100, 32'd5 << 2, 32'h00AA0000, 8'd5);
    wb_access("t2_sel0", 1'b1, 4'b0000, 32'd5 << 2, 32'hFFFFFFFF, 8'd5);
    wb_access("t2_rd",  1'b0, 4'hF, 32'd5 << 2, 32'h0, 8'd5);

    // Address aliasing on both ports
    wb_access("t5_wr", 1'b1, 4'hF, 32'd44 << 2, 32'h12345678, 8'd44);
    wb_access("t5_alias", 1'b0, 4'hF, 32'hF000_0000 | (32'd300 << 2), 32'h0, 8'd44);
    a300 = 300;
    ro_req = 1'b1; ro_addr = a300[7:0];
    ro_q.push_back(model[44]);
    @(negedge clk);
    chk("t5_ro_en", 32'(f1_ram_en), 32'd1);
    chk("t5_ro_a",  32'(f1_ram_a), 32'd44);
    chk("t5_ro_we", 32'(f1_ram_we), 32'd0);
    next_cycle();
    @(negedge clk);
    exp_d = ro_q.pop_front();
    chk("t5_ro_ack",  32'(f1_ro_ack), 32'd1);
    chk("t5_ro_data", f1_ro_data, exp_d);
    next_cycle();
    ro_req = 1'b0;
    @(negedge clk);
    chk("t5_ro_pulse", 32'(f1_ro_ack), 32'd0);
    chk("t5_ro_hold",  f1_ro_data, exp_d);
    next_cycle();
    @(negedge clk);
    chk("t5_ro_hold2", f1_ro_data, exp_d);
    chk("t5_stall0",   32'(f1_stall), 32'd0);
    next_cycle();

    // Contention right after reset, FAIR=1: WB, RO, WB, RO
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'd5 << 2;
    ro_req = 1'b1; ro_addr = 8'd44;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) begin
        wb_q.push_back(model[5]);
        ro_q.push_back(model[44]);
      end
      @(negedge clk);
      case (i % 4)
        0: chk("t3_grant_wb", 32'({f1_ram_en, f1_ram_a}), 32'({1'b1, 8'd5}));
        1: begin
          exp_d = wb_q.pop_front();
          chk("t3_wb_ack", 32'(f1_wb_ack), 32'd1);
          chk("t3_wb_dat", f1_wb_dat, exp_d);
        end
        2: chk("t3_grant_ro", 32'({f1_ram_en, f1_ram_a}), 32'({1'b1, 8'd44}));
        default: begin
          exp_d = ro_q.pop_front();
          chk("t3_ro_ack",  32'(f1_ro_ack), 32'd1);
          chk("t3_ro_data", f1_ro_data, exp_d);
        end
      endcase
      next_cycle();
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; ro_req = 1'b0;
    @(negedge clk);
    chk("t3_stall", 32'(f1_stall), 32'd8);
    chk("t3_idle",  32'(f1_ram_en), 32'd0);
    next_cycle();

    // FAIR=0 starvation and counter saturation
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd5 << 2;
    ro_req = 1'b1; ro_addr = 8'd44;
    n_ro0 = 0; n_wb0 = 0; n_ro1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f0_ro_ack) n_ro0++;
      if (f0_wb_ack) n_wb0++;
      if (f1_ro_ack) n_ro1++;
      next_cycle();
    end
    @(negedge clk);
    chk("t4_stall20", 32'(f0_stall), 32'd20);
    chk("t4_ro_starved", 32'(n_ro0), 32'd0);
    chk("t4_wb_acks", 32'(n_wb0), 32'd10);
    chk("t4_fair_ro_acks", 32'(n_ro1), 32'd5);
    next_cycle();
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (f0_ro_ack) n_ro0++;
      next_cycle();
    end
    @(negedge clk);
    chk("t4_sat", 32'(f0_stall), 32'h0000FFFF);
    chk("t4_ro_starved_long", 32'(n_ro0), 32'd0);
    next_cycle();
    wb_cyc = 1'b0; wb_stb = 1'b0; ro_req = 1'b0;
    repeat (2) next_cycle();

    // Reset during WB_RESP of a write
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'd7 << 2; wb_dat = 32'hCAFEF00D;
    model[7] = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_grant_a", 32'({f1_ram_en, f1_ram_a}), 32'({1'b1, 8'd7}));
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_no_ack", 32'(f1_wb_ack), 32'd0);
    chk("t6_ram_off", 32'(f1_ram_en), 32'd0);
    next_cycle();
    rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("t6_post_ack",    32'(f1_wb_ack), 32'd0);
    chk("t6_post_roak",   32'(f1_ro_ack), 32'd0);
    chk("t6_post_rodata", f1_ro_data, 32'd0);
    chk("t6_post_stall",  32'(f1_stall), 32'd0);
    next_cycle();
    wb_access("t6_rd", 1'b0, 4'hF, 32'd7 << 2, 32'h0, 8'd7);

    // Cycle dropped in the response cycle: no ack
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'd7 << 2;
    @(negedge clk);
    chk("t6_drop_en", 32'(f1_ram_en), 32'd1);
    next_cycle();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    chk("t6_drop_ack", 32'(f1_wb_ack), 32'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
